// File: rtl/lpm_lookup.sv
// rtl/lpm_lookup.sv - 16/8/8 stride trie-walk lookup stage, one lookup in flight
module lpm_lookup (
    input  logic        CLK,
    input  logic        RST,
    input  logic [95:0] in_first,
    input  logic        in_first__RDY,
    output logic        in_deq__ENA,
    output logic        mem_req__ENA,
    output logic [31:0] mem_req_addr,
    input  logic        mem_req__RDY,
    input  logic        mem_resp__ENA,
    input  logic [31:0] mem_resp_data,
    output logic        out_enq__ENA,
    output logic [63:0] out_enq_v,
    input  logic        out_enq__RDY,
    output logic [31:0] lookups_count,
    output logic [15:0] stray_count
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_SEND = 2'd3
    } state_t;

    state_t      state;
    logic [31:0] key;
    logic [31:0] tag;
    logic [31:0] base;
    logic [1:0]  level;
    logic [30:0] result;
    logic [31:0] index;

    always_comb begin
        index = {24'd0, key[7:0]};
        case (level)
            2'd0:    index = {16'd0, key[31:16]};
            2'd1:    index = {24'd0, key[15:8]};
            default: index = {24'd0, key[7:0]};
        endcase
    end

    // Address is a pure function of registered state, so it stays stable while stalled.
    assign mem_req_addr = base + index;
    assign mem_req__ENA = (state == S_REQ);
    assign in_deq__ENA  = (state == S_IDLE) && in_first__RDY && !RST;
    assign out_enq__ENA = (state == S_SEND) && out_enq__RDY;
    assign out_enq_v    = {tag, 1'b0, result};

    always_ff @(posedge CLK) begin
        if (RST) begin
            state         <= S_IDLE;
            key           <= 32'd0;
            tag           <= 32'd0;
            base          <= 32'd0;
            level         <= 2'd0;
            result        <= 31'd0;
            lookups_count <= 32'd0;
            stray_count   <= 16'd0;
        end else begin
            // Responses only mean something while waiting; anything else is stray.
            if (mem_resp__ENA && (state != S_WAIT) && (stray_count != 16'hFFFF)) begin
                stray_count <= stray_count + 16'd1;
            end
            case (state)
                S_IDLE: begin
                    if (in_first__RDY) begin
                        key   <= in_first[31:0];
                        tag   <= in_first[63:32];
                        base  <= in_first[95:64];
                        level <= 2'd0;
                        state <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (mem_req__RDY) begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (mem_resp__ENA) begin
                        if (mem_resp_data[31] || (level == 2'd2)) begin
                            result <= mem_resp_data[30:0];
                            state  <= S_SEND;
                        end else begin
                            base  <= {1'b0, mem_resp_data[30:0]};
                            level <= level + 2'd1;
                            state <= S_REQ;
                        end
                    end
                end
                S_SEND: begin
                    if (out_enq__RDY) begin
                        lookups_count <= lookups_count + 32'd1;
                        state         <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lpm_lookup.sv
// tb/tb_lpm_lookup.sv - scoreboard bench for lpm_lookup with trie reference model
module tb_lpm_lookup;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [95:0] in_first = 96'd0;
    logic        in_rdy = 1'b0;
    logic        in_deq;
    logic        req_ena;
    logic [31:0] req_addr;
    logic        req_rdy = 1'b0;
    logic        resp_ena = 1'b0;
    logic [31:0] resp_data = 32'd0;
    logic        out_ena;
    logic [63:0] out_v;
    logic        out_rdy = 1'b0;
    logic [31:0] lookups;
    logic [15:0] stray;

    lpm_lookup dut (
        .CLK            (clk),
        .RST            (rst),
        .in_first       (in_first),
        .in_first__RDY  (in_rdy),
        .in_deq__ENA    (in_deq),
        .mem_req__ENA   (req_ena),
        .mem_req_addr   (req_addr),
        .mem_req__RDY   (req_rdy),
        .mem_resp__ENA  (resp_ena),
        .mem_resp_data  (resp_data),
        .out_enq__ENA   (out_ena),
        .out_enq_v      (out_v),
        .out_enq__RDY   (out_rdy),
        .lookups_count  (lookups),
        .stray_count    (stray)
    );

    initial forever #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    bit [31:0]   mem [bit [31:0]];
    logic [63:0] exp_q[$];
    logic [31:0] addr_q[$];
    logic [95:0] req_q[$];

    int req_mode = 1;
    int out_mode = 1;
    int lat = 1;
    int gap_pct = 0;
    int stray_left = 0;
    bit busy = 0;
    bit popped = 0;
    bit pend = 0;
    bit waiting_accept = 0;
    bit accept = 0;
    int delay = 0;
    int pop_cnt = 0, enq_cnt = 0, acc_cnt = 0, resp_cnt = 0;
    int pop_cyc = 0, enq_cyc = 0, acc_cyc = 0;
    int exp_lookups = 0;
    logic [31:0] acc_addr = 32'd0;
    logic [31:0] held_addr = 32'd0;
    logic [31:0] pend_addr = 32'd0;
    logic [63:0] last_out = 64'd0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Unknown trie entries are invented on first touch: 1/3 leaves, else a small next base.
    function automatic logic [31:0] memrd(input logic [31:0] a);
        logic [31:0] r;
        if (!mem.exists(a)) begin
            r = $urandom();
            if ($urandom_range(0, 2) == 0) mem[a] = {1'b1, r[30:0]};
            else                           mem[a] = {12'd0, r[19:0]};
        end
        return mem[a];
    endfunction

    function automatic logic [63:0] ref_lookup(input logic [95:0] r);
        logic [31:0] k, b, idx, a, d;
        k = r[31:0];
        b = r[95:64];
        for (int lvl = 0; lvl < 3; lvl++) begin
            if (lvl == 0)      idx = k >> 16;
            else if (lvl == 1) idx = (k >> 8) & 32'hFF;
            else               idx = k & 32'hFF;
            a = b + idx;
            addr_q.push_back(a);
            d = memrd(a);
            if (d[31] || lvl == 2) return {r[63:32], 1'b0, d[30:0]};
            b = d & 32'h7FFF_FFFF;
        end
        return 64'd0;
    endfunction

    // Upstream FIFO driver; expected response is pushed at the moment of the pop.
    initial forever begin
        @(posedge clk); #1;
        if (popped) begin
            req_q.delete(0);
            popped = 0;
        end
        in_rdy = (req_q.size() > 0) && ($urandom_range(0, 99) >= gap_pct);
        if (req_q.size() > 0) in_first = req_q[0];
        @(negedge clk);
        if (in_deq) begin
            check("pop_with_ready", in_rdy, 1);
            check("pop_while_busy", busy, 0);
            busy = 1;
            pop_cnt++;
            pop_cyc = cyc;
            exp_q.push_back(ref_lookup(in_first));
            popped = 1;
        end
    end

    initial forever begin
        @(posedge clk); #1;
        req_rdy = (req_mode == 2) ? 1'($urandom_range(0, 1)) : (req_mode == 1);
        out_rdy = (out_mode == 2) ? 1'($urandom_range(0, 1)) : (out_mode == 1);
    end

    // Memory model: checks request addresses, answers lat cycles after acceptance.
    initial forever begin
        @(negedge clk);
        accept = 0;
        if (req_ena) begin
            if (waiting_accept) check("req_addr_held", req_addr, held_addr);
            else if (addr_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_req actual=%h required=none", req_addr);
            end else check("req_addr", req_addr, addr_q.pop_front());
            accept = req_rdy;
            waiting_accept = !req_rdy;
            held_addr = req_addr;
            if (accept) begin
                acc_cnt++;
                acc_cyc = cyc;
                acc_addr = req_addr;
            end
        end
        @(posedge clk); #1;
        resp_ena = 0;
        if (accept) begin
            pend = 1;
            pend_addr = held_addr;
            delay = (lat == 0) ? $urandom_range(1, 4) : lat;
        end
        if (pend) begin
            delay--;
            if (delay == 0) begin
                resp_ena = 1;
                resp_data = memrd(pend_addr);
                pend = 0;
                resp_cnt++;
            end
        end else if (stray_left > 0) begin
            resp_ena = 1;
            resp_data = $urandom();
            stray_left--;
        end
    end

    initial forever begin
        @(negedge clk);
        if (out_ena) begin
            check("enq_with_ready", out_rdy, 1);
            enq_cnt++;
            enq_cyc = cyc;
            last_out = out_v;
            busy = 0;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_enq actual=%h required=none", out_v);
            end else begin
                check("enq_value", out_v, exp_q.pop_front());
                exp_lookups++;
            end
        end
    end

    task automatic wait_done(input int maxc);
        int n = 0;
        while ((req_q.size() > 0 || exp_q.size() > 0 || busy || pend || stray_left > 0) && n < maxc) begin
            @(posedge clk);
            n++;
        end
        check("drain_in_time", (n < maxc) ? 1 : 0, 1);
        repeat (2) @(negedge clk);
    endtask

    task automatic pulse_reset();
        @(posedge clk); #2;
        rst = 1;
        @(posedge clk); #2;
        rst = 0;
        busy = 0;
        exp_q.delete();
        addr_q.delete();
        exp_lookups = 0;
    endtask

    initial begin
        int n, p0, e0, a0;
        // Reset with a request already waiting upstream.
        mem[32'h1A00] = 32'h8000_0055;
        req_q.push_back({32'h0000_1000, 32'd7, 32'h0A00_0001});
        repeat (3) begin
            @(negedge clk);
            check("deq_in_reset", in_deq, 0);
            check("req_in_reset", req_ena, 0);
            check("enq_in_reset", out_ena, 0);
        end
        check("lookups_reset", lookups, 0);
        check("stray_reset", stray, 0);
        @(posedge clk); #2;
        rst = 0;
        wait_done(100);
        check("l0_req_latency", acc_cyc - pop_cyc, 1);
        check("l0_req_addr", acc_addr, 32'h1A00);
        check("l0_enq_latency", enq_cyc - pop_cyc, 3);
        check("l0_value", last_out, {32'd7, 32'h0000_0055});
        check("l0_lookups", lookups, 1);

        // Full walk; level-2 entry without leaf bit still terminates.
        mem[32'h1A00] = 32'h0000_2000;
        mem[32'h2000] = 32'h0000_3000;
        mem[32'h3001] = 32'h0000_0099;
        req_q.push_back({32'h0000_1000, 32'd8, 32'h0A00_0001});
        wait_done(100);
        check("l2_enq_latency", enq_cyc - pop_cyc, 7);
        check("l2_last_addr", acc_addr, 32'h3001);
        check("l2_value", last_out, {32'd8, 32'h0000_0099});
        check("l2_lookups", lookups, exp_lookups);

        // Backpressure on both sides with a second request queued behind.
        mem[32'h5003] = 32'h8000_0011;
        mem[32'h6004] = 32'h8000_0022;
        req_mode = 0;
        out_mode = 0;
        p0 = pop_cnt;
        e0 = enq_cnt;
        a0 = resp_cnt;
        req_q.push_back({32'h0000_5000, 32'd21, 32'h0003_0000});
        req_q.push_back({32'h0000_6000, 32'd22, 32'h0004_0000});
        n = 0;
        while (pop_cnt == p0 && n < 50) begin @(posedge clk); n++; end
        check("bp_first_pop", (n < 50) ? 1 : 0, 1);
        repeat (5) @(posedge clk);
        req_mode = 1;
        n = 0;
        while (resp_cnt == a0 && n < 50) begin @(posedge clk); n++; end
        check("bp_resp", (n < 50) ? 1 : 0, 1);
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("bp_no_enq", enq_cnt, e0);
        check("bp_no_second_pop", pop_cnt, p0 + 1);
        out_mode = 1;
        wait_done(200);
        check("bp_enqs", enq_cnt, e0 + 2);
        check("bp_last_value", last_out, {32'd22, 32'h0000_0022});

        // Base + index wraps modulo 2^32.
        mem[32'h0000_0010] = 32'h8000_0123;
        req_q.push_back({32'hFFFF_FFF0, 32'd5, 32'h0020_ABCD});
        wait_done(100);
        check("wrap_addr", acc_addr, 32'h0000_0010);
        check("wrap_value", last_out, {32'd5, 32'h0000_0123});

        // Reset while waiting; the late response must land as a stray.
        lat = 3;
        mem[32'h7005] = 32'h8000_0044;
        a0 = acc_cnt;
        e0 = enq_cnt;
        req_q.push_back({32'h0000_7000, 32'd9, 32'h0005_0000});
        n = 0;
        while (acc_cnt == a0 && n < 50) begin @(posedge clk); #2; n++; end
        check("rw_accept", (n < 50) ? 1 : 0, 1);
        rst = 1;
        @(posedge clk); #2;
        rst = 0;
        busy = 0;
        exp_q.delete();
        addr_q.delete();
        exp_lookups = 0;
        repeat (5) @(negedge clk);
        check("rw_stray", stray, 1);
        check("rw_no_enq", enq_cnt, e0);
        check("rw_lookups", lookups, 0);
        lat = 1;
        req_q.push_back({32'h0000_7000, 32'd10, 32'h0005_0000});
        wait_done(100);
        check("rw_next_value", last_out, {32'd10, 32'h0000_0044});
        check("rw_next_lookups", lookups, 1);

        // Randomised traffic with random latency and backpressure.
        lat = 0;
        req_mode = 2;
        out_mode = 2;
        gap_pct = 30;
        for (int i = 0; i < 120; i++) begin
            req_q.push_back({32'($urandom()), 32'($urandom()), 32'($urandom())});
        end
        wait_done(8000);
        check("rand_lookups", lookups, exp_lookups);
        check("rand_stray", stray, 1);
        lat = 1;
        req_mode = 1;
        out_mode = 1;
        gap_pct = 0;

        // Strays while idle, then saturation.
        pulse_reset();
        @(negedge clk);
        check("stray_cleared", stray, 0);
        e0 = enq_cnt;
        stray_left = 3;
        wait_done(50);
        check("stray_three", stray, 3);
        check("stray_no_enq", enq_cnt, e0);
        stray_left = 69997;
        wait_done(72000);
        check("stray_saturate", stray, 16'hFFFF);
        check("stray_lookups", lookups, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #980000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
